// File: rtl/usb_tx_wire_writer_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_wire_writer_pkg
// Shared definitions for the final USB transmit stage: line-state codes,
// default bit-time dividers, FSM state encoding and the packed FIFO symbol.
// Optional feature macro used by the top level: USB_TX_UNDERRUN_DET_EN.
// -----------------------------------------------------------------------------
package usb_tx_wire_writer_pkg;

  // Line-state codes on {D+, D-}
  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] K_FS = 2'b01;
  localparam logic [1:0] J_FS = 2'b10;

  // Default clk cycles per USB bit (48 MHz clk)
  localparam int FS_DIV_DEF = 4;
  localparam int LS_DIV_DEF = 32;

  // Width of one queued symbol: {ctl, D+, D-}
  localparam int SYM_W = 3;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    TX_ACT    = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic       ctl;
    logic [1:0] bits;
  } tx_sym_t;

  // Larger of the two dividers, used to size the bit-time counter
  function automatic int max_div(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_tx_wire_writer_if.sv
// -----------------------------------------------------------------------------
// usb_tx_wire_writer_if
// Bundles the arbiter-facing handshake and the pad-facing outputs of the
// transmit wire writer.
//   master : arbiter/bench side  (drives symbols, speed select)
//   slave  : wire writer side    (drives ready, pad data/enable, underrun)
// Signals:
//   TxBitsIn[1:0]   line state, [1]=D+, [0]=D-
//   TxCtlIn         1 = drive line, 0 = release (end of packet)
//   USBWireWEn      push strobe
//   fullSpeedRate   1 = full speed divider, 0 = low speed divider
//   USBWireRdy      FIFO not full
//   USBWireData     registered D+/D-
//   USBWireCtrl     registered pad output enable
//   TxUnderrun      sticky underrun flag
// -----------------------------------------------------------------------------
interface usb_tx_wire_writer_if;
  import usb_tx_wire_writer_pkg::*;

  logic [1:0] TxBitsIn;
  logic       TxCtlIn;
  logic       USBWireWEn;
  logic       fullSpeedRate;
  logic       USBWireRdy;
  logic [1:0] USBWireData;
  logic       USBWireCtrl;
  logic       TxUnderrun;

  modport master (
    output TxBitsIn, TxCtlIn, USBWireWEn, fullSpeedRate,
    input  USBWireRdy, USBWireData, USBWireCtrl, TxUnderrun
  );

  modport slave (
    input  TxBitsIn, TxCtlIn, USBWireWEn, fullSpeedRate,
    output USBWireRdy, USBWireData, USBWireCtrl, TxUnderrun
  );

endinterface

// File: rtl/usb_tx_wire_writer_sym.sv
// -----------------------------------------------------------------------------
// usb_tx_sym_fifo
// Generic synchronous FIFO holding line symbols for the wire writer.
// Ports:
//   clk, rst         clock, synchronous active-low reset (flushes the FIFO)
//   push, push_data  write request and data; ignored while full
//   pop, pop_data    read request; pop_data shows the head entry
//   empty, count     occupancy status (count has one extra bit so that a
//                    full FIFO is distinguishable from an empty one)
// DEPTH must be a power of two, minimum 2.
// -----------------------------------------------------------------------------
module usb_tx_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A push while full is dropped even if a pop happens in the same cycle
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array needs no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_wire_writer.sv
// -----------------------------------------------------------------------------
// usb_tx_wire_writer
// Final transmit stage of the serial interface engine. Symbols from the tx
// wire arbiter are queued in a small FIFO and emitted one per USB bit time
// onto the registered D+/D- pad outputs and output enable.
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   usb_tx_wire_writer_if.slave (symbol handshake, speed select,
//         pad data/enable, underrun flag)
// Optional feature: define USB_TX_UNDERRUN_DET_EN to enable the sticky
// underrun detector; otherwise TxUnderrun is tied low.
// -----------------------------------------------------------------------------
module usb_tx_wire_writer
  import usb_tx_wire_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FS_DIV     = FS_DIV_DEF,
  parameter int LS_DIV     = LS_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  usb_tx_wire_writer_if.slave    bus
);

  localparam int DIV_W = $clog2(max_div(FS_DIV, LS_DIV));
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] FS_LAST = DIV_W'(FS_DIV - 1);
  localparam logic [DIV_W-1:0] LS_LAST = DIV_W'(LS_DIV - 1);

  tx_sym_t          push_sym;
  tx_sym_t          head_sym;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  tx_state_t        state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             div_is_fs;
  logic             strobe;
  logic             pop;
  logic [1:0]       data_q;
  logic             ctrl_q;

  assign push_sym = '{ctl: bus.TxCtlIn, bits: bus.TxBitsIn};

  // Speed is frozen per packet, so the terminal count comes from the latch
  assign div_last = div_is_fs ? FS_LAST : LS_LAST;
  assign strobe   = (state == TX_ACT) && (div_cnt == div_last);
  assign pop      = !fifo_empty && ((state == WAIT_DATA) || strobe);

  assign bus.USBWireRdy  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign bus.USBWireData = data_q;
  assign bus.USBWireCtrl = ctrl_q;

  usb_tx_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.USBWireWEn),
    .push_data (push_sym),
    .pop       (pop),
    .pop_data  (head_sym),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Transmit FSM, bit-time divider and pad output registers. A release
  // symbol (ctl=0) is loaded like any other but ends the packet at once;
  // an empty FIFO at a strobe simply stretches the current symbol.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT_DATA;
      div_cnt   <= '0;
      div_is_fs <= 1'b1;
      data_q    <= SE0;
      ctrl_q    <= 1'b0;
    end else begin
      case (state)
        WAIT_DATA: begin
          div_cnt <= '0;
          if (!fifo_empty) begin
            data_q    <= head_sym.bits;
            ctrl_q    <= head_sym.ctl;
            div_is_fs <= bus.fullSpeedRate;
            state     <= TX_ACT;
          end
        end
        TX_ACT: begin
          if (strobe) begin
            div_cnt <= '0;
            if (!fifo_empty) begin
              data_q <= head_sym.bits;
              ctrl_q <= head_sym.ctl;
              if (!head_sym.ctl) begin
                state <= WAIT_DATA;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= WAIT_DATA;
        end
      endcase
    end
  end

`ifdef USB_TX_UNDERRUN_DET_EN
  logic underrun_q;

  // Sticky underrun: set on an empty strobe, cleared when a new packet starts
  always_ff @(posedge clk) begin
    if (!rst) begin
      underrun_q <= 1'b0;
    end else if ((state == WAIT_DATA) && !fifo_empty) begin
      underrun_q <= 1'b0;
    end else if (strobe && fifo_empty) begin
      underrun_q <= 1'b1;
    end
  end

  assign bus.TxUnderrun = underrun_q;
`else
  assign bus.TxUnderrun = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_wire_writer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_wire_writer
// Self-checking bench for usb_tx_wire_writer: directed scenarios checked
// against hand-derived cycle positions, followed by randomized traffic
// checked every cycle against a queue-based behavioural model.
// Honours USB_TX_UNDERRUN_DET_EN for the expected underrun behaviour.
// -----------------------------------------------------------------------------
module tb_usb_tx_wire_writer;

  localparam int DEPTH = 4;
`ifdef USB_TX_UNDERRUN_DET_EN
  localparam logic UND_EN = 1'b1;
`else
  localparam logic UND_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  usb_tx_wire_writer_if bus ();

  usb_tx_wire_writer #(
    .FIFO_DEPTH (DEPTH),
    .FS_DIV     (4),
    .LS_DIV     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;
  logic [4:0] hist [0:8191];

  // Reference model state: pending symbols, pad value, and how long the
  // current symbol has been shown versus its bit time
  logic [2:0] mq [$];
  logic [1:0] m_data;
  logic       m_ctrl;
  logic       m_active;
  logic       m_und;
  int         m_age;
  int         m_bit;
  logic       m_was_full;
  logic [2:0] m_head;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count of active edges seen so far, used to index the output history
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] sym);
    bus.USBWireWEn = we;
    bus.TxCtlIn    = sym[2];
    bus.TxBitsIn   = sym[1:0];
    @(negedge clk);
  endtask

  // Behavioural model: each queued symbol is shown for m_bit cycles; when
  // its time is up the next one is taken, or the current one is stretched
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_data   = 2'b00;
      m_ctrl   = 1'b0;
      m_active = 1'b0;
      m_und    = 1'b0;
      m_age    = 0;
      m_bit    = 4;
    end else begin
      m_was_full = (mq.size() >= DEPTH);
      if (!m_active) begin
        if (mq.size() > 0) begin
          m_head   = mq.pop_front();
          m_data   = m_head[1:0];
          m_ctrl   = m_head[2];
          m_active = 1'b1;
          m_age    = 0;
          m_bit    = bus.fullSpeedRate ? 4 : 32;
          m_und    = 1'b0;
        end
      end else begin
        m_age = m_age + 1;
        if (m_age == m_bit) begin
          m_age = 0;
          if (mq.size() > 0) begin
            m_head = mq.pop_front();
            m_data = m_head[1:0];
            m_ctrl = m_head[2];
            if (!m_head[2]) m_active = 1'b0;
          end else begin
            m_und = UND_EN;
          end
        end
      end
      if (bus.USBWireWEn && !m_was_full) begin
        mq.push_back({bus.TxCtlIn, bus.TxBitsIn});
      end
    end
  end

  // Record the outputs every cycle and compare them against the model
  always @(negedge clk) begin
    if (cyc < 8192) begin
      hist[cyc] = {bus.USBWireRdy, bus.TxUnderrun, bus.USBWireCtrl, bus.USBWireData};
    end
    if (chk_en) begin
      checkOutput("model_data", {6'd0, bus.USBWireData}, {6'd0, m_data});
      checkOutput("model_ctrl", {7'd0, bus.USBWireCtrl}, {7'd0, m_ctrl});
      checkOutput("model_rdy",  {7'd0, bus.USBWireRdy},  {7'd0, mq.size() < DEPTH});
      checkOutput("model_und",  {7'd0, bus.TxUnderrun},  {7'd0, m_und});
    end
  end

  function automatic logic [7:0] padAt(input int at);
    return {5'd0, hist[at][2:0]};
  endfunction

  initial begin
    int c;
    int d;
    rst               = 1'b0;
    bus.fullSpeedRate = 1'b1;
    bus.USBWireWEn    = 1'b1;
    bus.TxCtlIn       = 1'b1;
    bus.TxBitsIn      = 2'b01;

    // Reset held with a push request active
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("rst_rdy",  {7'd0, bus.USBWireRdy},  8'd1);
    checkOutput("rst_ctrl", {7'd0, bus.USBWireCtrl}, 8'd0);
    checkOutput("rst_data", {6'd0, bus.USBWireData}, 8'd0);
    checkOutput("rst_und",  {7'd0, bus.TxUnderrun},  8'd0);
    rst = 1'b1;
    repeat (4) applyStimulus(1'b0, 3'b000);
    checkOutput("rst_nopush", {7'd0, bus.USBWireCtrl}, 8'd0);

    // Full-speed packet
    c = cyc;
    applyStimulus(1'b1, 3'b101);
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b100);
    applyStimulus(1'b1, 3'b010);
    repeat (16) applyStimulus(1'b0, 3'b000);
    checkOutput("fs_lat1",   padAt(c + 1),  8'h0);
    checkOutput("fs_s1a",    padAt(c + 2),  8'h5);
    checkOutput("fs_s1b",    padAt(c + 5),  8'h5);
    checkOutput("fs_s2a",    padAt(c + 6),  8'h6);
    checkOutput("fs_s2b",    padAt(c + 9),  8'h6);
    checkOutput("fs_s3a",    padAt(c + 10), 8'h4);
    checkOutput("fs_s3b",    padAt(c + 13), 8'h4);
    checkOutput("fs_rel",    padAt(c + 14), 8'h2);

    // Low-speed packet with speed toggling after the packet has started
    bus.fullSpeedRate = 1'b0;
    c = cyc;
    applyStimulus(1'b1, 3'b101);
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b100);
    applyStimulus(1'b1, 3'b010);
    for (int i = 0; i < 100; i++) begin
      bus.fullSpeedRate = ((i % 7) == 3);
      applyStimulus(1'b0, 3'b000);
    end
    bus.fullSpeedRate = 1'b1;
    applyStimulus(1'b0, 3'b000);
    checkOutput("ls_s1a", padAt(c + 2),  8'h5);
    checkOutput("ls_s1b", padAt(c + 33), 8'h5);
    checkOutput("ls_s2a", padAt(c + 34), 8'h6);
    checkOutput("ls_s2b", padAt(c + 65), 8'h6);
    checkOutput("ls_s3a", padAt(c + 66), 8'h4);
    checkOutput("ls_s3b", padAt(c + 97), 8'h4);
    checkOutput("ls_rel", padAt(c + 98), 8'h2);

    // Overfill: six pushes back to back, the sixth must be dropped
    c = cyc;
    applyStimulus(1'b1, 3'b101);
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b101);
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b011);
    applyStimulus(1'b1, 3'b101);
    repeat (24) applyStimulus(1'b0, 3'b000);
    checkOutput("full_rdy4", {7'd0, hist[c + 4][4]}, 8'd1);
    checkOutput("full_rdy5", {7'd0, hist[c + 5][4]}, 8'd0);
    checkOutput("full_rdy6", {7'd0, hist[c + 6][4]}, 8'd1);
    checkOutput("full_s4",   padAt(c + 17), 8'h6);
    checkOutput("full_rel",  padAt(c + 18), 8'h3);
    checkOutput("full_drop", padAt(c + 25), 8'h3);

    // Underrun: a lone drive symbol is stretched past its bit time
    c = cyc;
    applyStimulus(1'b1, 3'b101);
    repeat (11) applyStimulus(1'b0, 3'b000);
    checkOutput("und_hold", padAt(c + 9), 8'h5);
    checkOutput("und_pre",  {7'd0, hist[c + 5][3]}, 8'd0);
    checkOutput("und_set",  {7'd0, hist[c + 6][3]}, {7'd0, UND_EN});
    checkOutput("und_stk",  {7'd0, hist[c + 10][3]}, {7'd0, UND_EN});
    applyStimulus(1'b1, 3'b000);
    repeat (10) applyStimulus(1'b0, 3'b000);

    // Reset in the middle of the second symbol, then a fresh packet
    c = cyc;
    applyStimulus(1'b1, 3'b101);
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b101);
    repeat (4) applyStimulus(1'b0, 3'b000);
    rst = 1'b0;
    applyStimulus(1'b0, 3'b000);
    rst = 1'b1;
    d = cyc;
    applyStimulus(1'b1, 3'b110);
    applyStimulus(1'b1, 3'b001);
    repeat (10) applyStimulus(1'b0, 3'b000);
    checkOutput("mrst_pre",   padAt(c + 7), 8'h6);
    checkOutput("mrst_pad",   padAt(c + 8), 8'h0);
    checkOutput("mrst_rdy",   {7'd0, hist[c + 8][4]}, 8'd1);
    checkOutput("mrst_flush", padAt(d + 1), 8'h0);
    checkOutput("mrst_new",   padAt(d + 2), 8'h6);
    checkOutput("mrst_rel",   padAt(d + 6), 8'h1);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] sym;
      sym[1:0] = 2'($urandom_range(0, 3));
      sym[2]   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        bus.fullSpeedRate = ~bus.fullSpeedRate;
      end
      rst = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 99) < 45, sym);
    end
    rst = 1'b1;
    repeat (40) applyStimulus(1'b0, 3'b000);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
